// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: external ALU
// control codes and FSM state encodings.
package alu_mul_seq_pkg;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_MUL = 3'b011,
    ALU_SUB = 3'b110
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier borrowing the external ALU adder, one bit per cycle.
// Optional macro ALU_MUL_SEQ_EARLY_EXIT_EN ends RUN once the remaining multiplier is zero.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o,
  output logic [WIDTH-1:0] alu_data1_o,
  output logic [WIDTH-1:0] alu_data2_o,
  output logic [2:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_result_i
);

  localparam int CW = $clog2(WIDTH);

  mul_state_e       r_state;
  mul_state_e       w_state_next;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_product;
  logic [CW-1:0]    r_count;

  logic             w_start_accept;
  logic             w_last_cycle;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_mplier_shift;

  assign w_start_accept = (r_state == IDLE) && start_i;
  assign w_mplier_shift = r_mplier >> 1;
  // The ALU sums acc + mcand; a zero multiplier bit simply keeps acc.
  assign w_acc_next     = r_mplier[0] ? alu_result_i : r_acc;

`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
  assign w_last_cycle = (w_mplier_shift == '0) || (r_count == CW'(WIDTH - 1));
`else
  assign w_last_cycle = (r_count == CW'(WIDTH - 1));
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every signal driven from always_comb gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start_i) w_state_next = RUN;
      RUN:     if (w_last_cycle) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = 1'b0;
    done_o      = 1'b0;
    alu_ctrl_o  = ALU_AND;
    alu_data1_o = '0;
    alu_data2_o = '0;
    unique case (r_state)
      RUN: begin
        busy_o      = 1'b1;
        alu_ctrl_o  = ALU_ADD;
        alu_data1_o = r_acc;
        alu_data2_o = r_mcand;
      end
      DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Start requests outside IDLE fall through untouched, so operands stay stable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else if (w_start_accept) begin
      r_acc    <= '0;
      r_mcand  <= a_i;
      r_mplier <= b_i;
      r_count  <= '0;
    end else if (r_state == RUN) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= w_mplier_shift;
      r_count  <= r_count + CW'(1);
      if (w_last_cycle) begin
        r_product <= w_acc_next;
      end
    end
  end

  assign product_o = r_product;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: models the external ALU, runs directed
// vectors, randomized operands and the start/reset corner sequences.
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy_o;
  logic        done_o;
  logic [31:0] product_o;
  logic [31:0] alu_data1_o;
  logic [31:0] alu_data2_o;
  logic [2:0]  alu_ctrl_o;
  logic [31:0] alu_result;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mul_seq #(.WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .a_i         (a),
    .b_i         (b),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .product_o   (product_o),
    .alu_data1_o (alu_data1_o),
    .alu_data2_o (alu_data2_o),
    .alu_ctrl_o  (alu_ctrl_o),
    .alu_result_i(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU as seen by the multiplier.
  always_comb begin
    alu_result = '0;
    case (alu_ctrl_o)
      ALU_AND: alu_result = alu_data1_o & alu_data2_o;
      ALU_OR:  alu_result = alu_data1_o | alu_data2_o;
      ALU_ADD: alu_result = alu_data1_o + alu_data2_o;
      ALU_MUL: alu_result = alu_data1_o * alu_data2_o;
      ALU_SUB: alu_result = alu_data1_o - alu_data2_o;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Cycles from accepting edge to the done pulse, inclusive of DONE.
  function automatic int exp_cycles(input logic [31:0] op_b);
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
    int k;
    k = 1;
    while (k < 32 && (op_b >> k) != 0) k++;
    return k + 1;
`else
    return 33;
`endif
  endfunction

  // Called just after a falling edge; returns just after a falling edge in IDLE.
  task automatic do_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                       input logic [31:0] exp_prod, input int extra_at,
                       input logic [31:0] xa, input logic [31:0] xb);
    int cyc;
    int exp_cyc;
    bit busy_ok;
    bit ctrl_ok;
    exp_cyc = exp_cycles(op_b);
    start = 1'b1;
    a     = op_a;
    b     = op_b;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    a       = $urandom;
    b       = $urandom;
    cyc     = 1;
    busy_ok = 1'b1;
    ctrl_ok = 1'b1;
    while (!done_o && cyc < 100) begin
      if (!busy_o) busy_ok = 1'b0;
      if (alu_ctrl_o !== 3'b010) ctrl_ok = 1'b0;
      start = (cyc == extra_at);
      if (start) begin
        a = xa;
        b = xb;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(exp_cyc));
    check({tag, " busy_in_run"}, 64'(busy_ok), 64'd1);
    check({tag, " run_alu_ctrl"}, 64'(ctrl_ok), 64'd1);
    check({tag, " product"}, 64'(product_o), 64'(exp_prod));
    check({tag, " done_state_outs"}, {busy_o, alu_ctrl_o, alu_data1_o | alu_data2_o},
          {1'b1, 3'b000, 32'h0});
    start = (cyc == extra_at);
    if (start) begin
      a = xa;
      b = xb;
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, " idle_after_done"}, {62'h0, busy_o, done_o}, 64'h0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int          cyc;
    bit          saw_done;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{32'd6,          32'd7,          32'd42};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
    vecs[2] = '{32'd5,          32'd0,          32'd0};
    vecs[3] = '{32'd0,          32'hFFFF_FFFF,  32'd0};
    vecs[4] = '{32'd1,          32'h1234_5678,  32'h1234_5678};
    vecs[5] = '{32'h8000_0000,  32'd2,          32'd0};
    vecs[6] = '{32'h0001_0000,  32'h0001_0001,  32'h0001_0000};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy_o, done_o, alu_ctrl_o, product_o, alu_data1_o, alu_data2_o}, '0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod, 0, '0, '0);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      do_op($sformatf("rand%0d", i), ra, rb, ra * rb, 0, '0, '0);
    end

    // Start during RUN must leave the first operation untouched.
    do_op("start_mid_run", 32'd3, 32'd4, 32'd12, 2, 32'd9, 32'd9);

    // Start in DONE is ignored; the next IDLE cycle's start is accepted.
    do_op("b2b_first", 32'd10, 32'd13, 32'd130, exp_cycles(32'd13), 32'd9, 32'd9);
    do_op("b2b_second", 32'd7, 32'd11, 32'd77, 0, '0, '0);

    // Reset in the middle of RUN aborts with no done pulse.
    start = 1'b1;
    a     = 32'd100;
    b     = 32'd200;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (cyc < 10) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("pre_abort_busy", 64'(busy_o), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_outputs", {busy_o, done_o, alu_ctrl_o, product_o, alu_data1_o, alu_data2_o}, '0);
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o || busy_o) saw_done = 1'b1;
    end
    check("no_done_after_abort", 64'(saw_done), 64'd0);
    do_op("after_abort", 32'd2, 32'd3, 32'd6, 0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
